// File: rtl/cpu_core_param.sv
// cpu_core_param: multicycle fetch/exec CPU core with 8 registers, Z/C flags and
// req/ack instruction and data memory ports.
module cpu_core_param #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    output logic [DATA_W-1:0] dmem_addr,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [DATA_W-1:0] out_port,
    output logic              out_strobe,
    output logic              halted
);
    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;
    state_t state, state_n;
    logic [PC_W-1:0] pc, target;
    logic [15:0] ir;
    logic [DATA_W-1:0] regs [8];
    logic [DATA_W-1:0] a, b, d, imm, res;
    logic [DATA_W:0] sum;
    logic [3:0] op;
    logic [2:0] rd;
    logic z, c, c_n, wr_rd, wr_fl, taken, mem_op;
    assign op = ir[15:12];
    assign rd = ir[11:9];
    assign a = regs[ir[8:6]];
    assign b = regs[ir[5:3]];
    assign d = regs[rd];
    assign imm = DATA_W'(ir[7:0]);
    assign mem_op = op == 4'h8 || op == 4'h9;
    assign taken = op == 4'hA || (op == 4'hB && z) || (op == 4'hC && c);
    // jumps stay inside the current 256-word page
    assign target = PC_W'(ir[7:0]) | (pc & ~PC_W'(8'hFF));
    // outputs drop the instant rst rises, even before the state register settles
    assign imem_req = state == FETCH && !rst;
    assign imem_addr = pc;
    assign dmem_req = state == MEM && !rst;
    assign dmem_we = dmem_req && op == 4'h9;
    assign dmem_addr = a;
    assign dmem_wdata = b;
    assign halted = state == HALT;
    always_comb begin
        sum = '0;
        res = '0;
        c_n = c;
        wr_rd = 1'b0;
        wr_fl = 1'b0;
        case (op)
            4'h1: begin res = imm; wr_rd = 1'b1; end
            4'h2: begin sum = {1'b0, a} + {1'b0, b}; res = sum[DATA_W-1:0]; c_n = sum[DATA_W]; wr_rd = 1'b1; wr_fl = 1'b1; end
            4'h3: begin sum = {1'b0, a} - {1'b0, b}; res = sum[DATA_W-1:0]; c_n = sum[DATA_W]; wr_rd = 1'b1; wr_fl = 1'b1; end
            4'h4: begin res = a & b; c_n = 1'b0; wr_rd = 1'b1; wr_fl = 1'b1; end
            4'h5: begin res = a | b; c_n = 1'b0; wr_rd = 1'b1; wr_fl = 1'b1; end
            4'h6: begin res = a ^ b; c_n = 1'b0; wr_rd = 1'b1; wr_fl = 1'b1; end
            4'h7: begin sum = {1'b0, d} + {1'b0, imm}; res = sum[DATA_W-1:0]; c_n = sum[DATA_W]; wr_rd = 1'b1; wr_fl = 1'b1; end
            default: ;
        endcase
    end
    always_comb begin
        state_n = state;
        if (state == FETCH && imem_ack) state_n = EXEC;
        else if (state == EXEC) state_n = mem_op ? MEM : op == 4'hF ? HALT : FETCH;
        else if (state == MEM && dmem_ack) state_n = FETCH;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc <= '0;
            ir <= '0;
            z <= 1'b0;
            c <= 1'b0;
            out_port <= '0;
            out_strobe <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            state <= state_n;
            out_strobe <= state == EXEC && op == 4'hD;
            if (state == FETCH && imem_ack) ir <= imem_data;
            if (state == EXEC) begin
                if (op != 4'hF) pc <= taken ? target : pc + PC_W'(1);
                if (wr_rd) regs[rd] <= res;
                if (wr_fl) begin
                    z <= res == '0;
                    c <= c_n;
                end
                if (op == 4'hD) out_port <= a;
            end
            if (state == MEM && dmem_ack && op == 4'h8) regs[rd] <= dmem_rdata;
        end
    end
endmodule

// File: tb/tb_cpu_core_param.sv
// tb_cpu_core_param: scoreboard bench for cpu_core_param with wait-state memory models,
// plus a second wide build for page jumps and PC wrap.
module tb_cpu_core_param;
    logic clk = 0, rst = 1, rst_b = 1;
    int checks = 0, errors = 0, cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, out_port;
    logic [15:0] imem_data;
    logic imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, out_strobe, halted;
    cpu_core_param #(.DATA_W(8), .PC_W(8)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_data(imem_data), .dmem_addr(dmem_addr), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .out_port(out_port), .out_strobe(out_strobe), .halted(halted));

    logic [9:0] b_imem_addr;
    logic [15:0] b_imem_data, b_dmem_addr, b_dmem_wdata, b_dmem_rdata, b_out_port;
    logic b_imem_req, b_imem_ack, b_dmem_req, b_dmem_we, b_dmem_ack, b_out_strobe, b_halted;
    cpu_core_param #(.DATA_W(16), .PC_W(10)) dut_b (
        .clk(clk), .rst(rst_b), .imem_addr(b_imem_addr), .imem_req(b_imem_req), .imem_ack(b_imem_ack),
        .imem_data(b_imem_data), .dmem_addr(b_dmem_addr), .dmem_req(b_dmem_req), .dmem_we(b_dmem_we),
        .dmem_wdata(b_dmem_wdata), .dmem_rdata(b_dmem_rdata), .dmem_ack(b_dmem_ack),
        .out_port(b_out_port), .out_strobe(b_out_strobe), .halted(b_halted));

    logic [15:0] rom_a [256];
    logic [7:0] ram_a [256];
    logic [15:0] rom_b [1024];
    int iwait = 0, dwait = 0, dacc = 0, ic = 0, dc = 0;
    int fcyc [$];
    logic [7:0] exp_fetch [$], exp_out [$];
    logic [15:0] exp_out_b [$];
    logic [9:0] bf [$];
    logic p_ireq = 0, p_iack = 0, p_dreq = 0, p_dack = 0, p_we = 0, p_str = 0, p_str_b = 0;
    logic [7:0] p_iaddr = 0, p_daddr = 0, p_dw = 0, e8;
    logic [15:0] e16;
    int fseq [20] = '{'h00, 'h01, 'h02, 'h03, 'h05, 'h06, 'h07, 'h08, 'h09, 'h10,
                      'h11, 'h12, 'h13, 'h14, 'h15, 'h16, 'h17, 'h18, 'h1B, 'h1C};
    int oseq [5] = '{44, 0, 200, 0, 0};

    // memory models and output monitor for the 8-bit core
    initial begin
        imem_ack = 0; imem_data = 0; dmem_ack = 0; dmem_rdata = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ic = 0; dc = 0; imem_ack = 0; dmem_ack = 0; p_ireq = 0; p_dreq = 0; p_str = 0;
            end else begin
                if (p_ireq && !p_iack) begin
                    checks++;
                    if (!imem_req || imem_addr !== p_iaddr) begin
                        errors++;
                        $display("FAIL imem_hold: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, p_iaddr);
                    end
                end
                if (p_dreq && !p_dack) begin
                    checks++;
                    if (!dmem_req || dmem_addr !== p_daddr || dmem_we !== p_we || dmem_wdata !== p_dw) begin
                        errors++;
                        $display("FAIL dmem_hold: req=%b addr=%h we=%b wdata=%h, expected 1 %h %b %h",
                                 dmem_req, dmem_addr, dmem_we, dmem_wdata, p_daddr, p_we, p_dw);
                    end
                end
                if (out_strobe) begin
                    checks++;
                    if (p_str) begin
                        errors++;
                        $display("FAIL strobe_width: strobe high 2 cycles, expected 1");
                    end else if (exp_out.size() == 0) begin
                        errors++;
                        $display("FAIL out_extra: got %h, expected no output", out_port);
                    end else begin
                        e8 = exp_out.pop_front();
                        if (out_port !== e8) begin
                            errors++;
                            $display("FAIL out_port: got %h, expected %h", out_port, e8);
                        end
                    end
                end
                p_str = out_strobe;
                if (imem_req && ic < iwait) begin
                    ic++; imem_ack = 0;
                end else if (imem_req) begin
                    ic = 0; imem_ack = 1; imem_data = rom_a[imem_addr]; fcyc.push_back(cyc);
                    checks++;
                    if (exp_fetch.size() == 0) begin
                        errors++;
                        $display("FAIL fetch_extra: fetch at %h, expected none", imem_addr);
                    end else begin
                        e8 = exp_fetch.pop_front();
                        if (imem_addr !== e8) begin
                            errors++;
                            $display("FAIL fetch_addr: got %h, expected %h", imem_addr, e8);
                        end
                    end
                end else imem_ack = 0;
                if (dmem_req && dc < dwait) begin
                    dc++; dmem_ack = 0;
                end else if (dmem_req) begin
                    dc = 0; dmem_ack = 1; dacc++;
                    if (dmem_we) ram_a[dmem_addr] = dmem_wdata;
                    else dmem_rdata = ram_a[dmem_addr];
                end else dmem_ack = 0;
                p_ireq = imem_req; p_iack = imem_ack; p_iaddr = imem_addr;
                p_dreq = dmem_req; p_dack = dmem_ack; p_daddr = dmem_addr; p_we = dmem_we; p_dw = dmem_wdata;
            end
        end
    end

    // zero-wait memory and output monitor for the wide core
    initial begin
        b_imem_ack = 0; b_imem_data = 0; b_dmem_ack = 0; b_dmem_rdata = 0;
        forever begin
            @(negedge clk);
            if (rst_b) begin
                b_imem_ack = 0; b_dmem_ack = 0; p_str_b = 0;
            end else begin
                if (b_out_strobe) begin
                    checks++;
                    if (p_str_b) begin
                        errors++;
                        $display("FAIL b_strobe_width: strobe high 2 cycles, expected 1");
                    end else if (exp_out_b.size() == 0) begin
                        errors++;
                        $display("FAIL b_out_extra: got %h, expected no output", b_out_port);
                    end else begin
                        e16 = exp_out_b.pop_front();
                        if (b_out_port !== e16) begin
                            errors++;
                            $display("FAIL b_out_port: got %h, expected %h", b_out_port, e16);
                        end
                    end
                end
                p_str_b = b_out_strobe;
                b_imem_ack = b_imem_req;
                if (b_imem_req) begin
                    b_imem_data = rom_b[b_imem_addr];
                    bf.push_back(b_imem_addr);
                end
                b_dmem_ack = b_dmem_req;
            end
        end
    end

    task automatic restart_a();
        rst = 1;
        fcyc.delete(); exp_fetch.delete(); exp_out.delete(); dacc = 0;
        @(negedge clk);
    endtask

    task automatic load_a();
        for (int i = 0; i < 256; i++) begin rom_a[i] = 16'hD0C0; ram_a[i] = 0; end
        rom_a[8'h00] = 16'h12C8; rom_a[8'h01] = 16'h1464; rom_a[8'h02] = 16'h2650; rom_a[8'h03] = 16'hC005;
        rom_a[8'h05] = 16'hB007; rom_a[8'h06] = 16'hD0C0; rom_a[8'h07] = 16'h3890; rom_a[8'h08] = 16'hC00A;
        rom_a[8'h09] = 16'hB010; rom_a[8'h10] = 16'hD100; rom_a[8'h11] = 16'h1A20; rom_a[8'h12] = 16'h9148;
        rom_a[8'h13] = 16'h8D40; rom_a[8'h14] = 16'hD180; rom_a[8'h15] = 16'h6E48; rom_a[8'h16] = 16'hD1C0;
        rom_a[8'h17] = 16'h7238; rom_a[8'h18] = 16'hC01B; rom_a[8'h1B] = 16'hD040; rom_a[8'h1C] = 16'hF000;
        foreach (fseq[i]) exp_fetch.push_back(8'(fseq[i]));
        foreach (oseq[i]) exp_out.push_back(8'(oseq[i]));
    endtask

    task automatic run_a(input int bound, output bit ok);
        for (int i = 0; i < bound && !halted; i++) @(negedge clk);
        ok = halted;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({imem_req, dmem_req, dmem_we, out_strobe, halted} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req/dreq/we/strobe/halted=%b, expected 00000",
                     {imem_req, dmem_req, dmem_we, out_strobe, halted});
        end
        checks++;
        if (out_port !== 8'h00 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: out_port=%h pc=%h, expected 00 00", out_port, imem_addr);
        end
        restart_a();
        load_a();
        @(posedge clk); #1 rst = 0; #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL first_fetch: req=%b addr=%h, expected 1 00", imem_req, imem_addr);
        end
    endtask

    task automatic test_basic();
        bit ok;
        run_a(400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_halt: halted=%b, expected 1 within 400 cycles", halted); end
        checks++;
        if (exp_fetch.size() != 0 || exp_out.size() != 0) begin
            errors++;
            $display("FAIL basic_pending: fetches=%0d outs=%0d left, expected 0 0", exp_fetch.size(), exp_out.size());
        end
        checks++;
        if (dacc != 2 || ram_a[8'h20] !== 8'd200) begin
            errors++;
            $display("FAIL basic_mem: accesses=%0d M[20]=%0d, expected 2 200", dacc, ram_a[8'h20]);
        end
        checks++;
        if (fcyc[1] - fcyc[0] != 2 || fcyc[2] - fcyc[1] != 2) begin
            errors++;
            $display("FAIL basic_cpi: %0d %0d cycles, expected 2 2", fcyc[1] - fcyc[0], fcyc[2] - fcyc[1]);
        end
        checks++;
        if (fcyc[12] - fcyc[11] != 3 || fcyc[13] - fcyc[12] != 3) begin
            errors++;
            $display("FAIL basic_mem_cpi: st=%0d ld=%0d cycles, expected 3 3", fcyc[12] - fcyc[11], fcyc[13] - fcyc[12]);
        end
    endtask

    task automatic test_halt();
        int n = fcyc.size();
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (imem_req || dmem_req || !halted) begin
                errors++;
                $display("FAIL halt_idle: req=%b dreq=%b halted=%b, expected 0 0 1", imem_req, dmem_req, halted);
            end
        end
        checks++;
        if (fcyc.size() != n) begin errors++; $display("FAIL halt_fetch: %0d fetches, expected %0d", fcyc.size(), n); end
    endtask

    task automatic test_wait_states();
        bit ok;
        restart_a();
        iwait = 2; dwait = 3;
        load_a();
        @(posedge clk); #1 rst = 0;
        run_a(800, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wait_halt: halted=%b, expected 1 within 800 cycles", halted); end
        checks++;
        if (exp_fetch.size() != 0 || exp_out.size() != 0 || fcyc.size() != 20 || dacc != 2) begin
            errors++;
            $display("FAIL wait_counts: left %0d/%0d fetches=%0d acc=%0d, expected 0/0 20 2",
                     exp_fetch.size(), exp_out.size(), fcyc.size(), dacc);
        end
        checks++;
        if (fcyc[1] - fcyc[0] != 4) begin errors++; $display("FAIL wait_cpi: %0d cycles, expected 4", fcyc[1] - fcyc[0]); end
        checks++;
        if (fcyc[12] - fcyc[11] != 8 || fcyc[13] - fcyc[12] != 8) begin
            errors++;
            $display("FAIL wait_mem_cpi: st=%0d ld=%0d cycles, expected 8 8", fcyc[12] - fcyc[11], fcyc[13] - fcyc[12]);
        end
    endtask

    task automatic test_reset_mid_mem();
        restart_a();
        iwait = 0; dwait = 20;
        for (int i = 0; i < 256; i++) begin rom_a[i] = 16'h0000; ram_a[i] = 0; end
        rom_a[8'h00] = 16'h1A30;
        rom_a[8'h01] = 16'h9168;
        exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h01);
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 20 && !dmem_req; i++) @(negedge clk);
        checks++;
        if (!dmem_req) begin errors++; $display("FAIL mid_mem_reach: dmem_req=%b, expected 1", dmem_req); end
        @(posedge clk); #2 rst = 1; #1;
        checks++;
        if ({imem_req, dmem_req, dmem_we, out_strobe, halted} !== 5'b0 || imem_addr !== 0 ||
            dmem_addr !== 0 || dmem_wdata !== 0 || out_port !== 0) begin
            errors++;
            $display("FAIL mid_mem_reset: ctl=%b pc=%h da=%h wd=%h out=%h, expected all 0",
                     {imem_req, dmem_req, dmem_we, out_strobe, halted}, imem_addr, dmem_addr, dmem_wdata, out_port);
        end
        checks++;
        if (dacc != 0 || ram_a[8'h30] !== 8'h00) begin
            errors++;
            $display("FAIL mid_mem_abort: accesses=%0d M[30]=%h, expected 0 00", dacc, ram_a[8'h30]);
        end
        exp_fetch.delete(); fcyc.delete();
        exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h01);
        @(posedge clk); #1 rst = 0;
        repeat (4) @(negedge clk);
        checks++;
        if (fcyc.size() != 2 || exp_fetch.size() != 0) begin
            errors++;
            $display("FAIL mid_mem_restart: fetches=%0d left=%0d, expected 2 0", fcyc.size(), exp_fetch.size());
        end
        rst = 1;
    endtask

    task automatic test_wide();
        bit j1 = 0, j2 = 0;
        int i = 0;
        for (int k = 0; k < 1024; k++) rom_b[k] = 16'h0000;
        rom_b[10'h000] = 16'hB040; rom_b[10'h001] = 16'hA050; rom_b[10'h040] = 16'hD040; rom_b[10'h041] = 16'hF000;
        rom_b[10'h200] = 16'hA0F0; rom_b[10'h2F0] = 16'hA005;
        rom_b[10'h205] = 16'h1200; rom_b[10'h206] = 16'h1401; rom_b[10'h207] = 16'h3250; rom_b[10'h208] = 16'hD040;
        rom_b[10'h209] = 16'h7201; rom_b[10'h20A] = 16'hD040; rom_b[10'h20B] = 16'hC00E; rom_b[10'h20C] = 16'hD080;
        rom_b[10'h20D] = 16'hD080; rom_b[10'h20E] = 16'hB010; rom_b[10'h20F] = 16'hD080; rom_b[10'h210] = 16'hA0F8;
        exp_out_b.delete(); bf.delete();
        exp_out_b.push_back(16'hFFFF); exp_out_b.push_back(16'h0000); exp_out_b.push_back(16'h0000);
        @(posedge clk); #1 rst_b = 0;
        while (i < 5000 && !b_halted) begin @(negedge clk); i++; end
        checks++;
        if (!b_halted) begin errors++; $display("FAIL wide_halt: halted=%b, expected 1 within 5000 cycles", b_halted); end
        for (int k = 0; k + 1 < bf.size(); k++) begin
            if (bf[k] == 10'h2F0 && bf[k+1] == 10'h205) j1 = 1;
            if (bf[k] == 10'h3FF && bf[k+1] == 10'h000) j2 = 1;
        end
        checks++;
        if (!j1) begin errors++; $display("FAIL wide_page_jump: 2F0->205 seen=%b, expected 1", j1); end
        checks++;
        if (!j2) begin errors++; $display("FAIL wide_pc_wrap: 3FF->000 seen=%b, expected 1", j2); end
        checks++;
        if (exp_out_b.size() != 0 || bf[bf.size()-1] !== 10'h041) begin
            errors++;
            $display("FAIL wide_end: outs left=%0d last fetch=%h, expected 0 041", exp_out_b.size(), bf[bf.size()-1]);
        end
        rst_b = 1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_halt();
        test_wait_states();
        test_halt();
        test_reset_mid_mem();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
